// File: rtl/rv32i_memory_responder.sv
// rv32i_memory_responder: memory-side responder for the multicycle RV32I core.
// Decodes each byte address into word RAM, a 16-byte MMIO window (LEDS, TX FIFO,
// STATUS, CYCLE) or unmapped space. Reads are registered with one cycle of
// latency and are read-first. Misaligned writes are suppressed and latch a
// sticky fault.
// Optional feature macro: RESPONDER_CYCLE_COUNTER_EN builds the CYCLE counter
// at MMIO +0xC; without it that register reads 0 and ignores writes.
module rv32i_memory_responder #(
    parameter int unsigned RAM_WORDS     = 512,
    parameter logic [31:0] MMIO_BASE     = 32'hF000_0000,
    parameter int unsigned TX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr_ena,
    output logic [31:0] mem_rd_data,
    output logic [15:0] leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam logic [32:0] RAM_LIMIT = 33'(RAM_WORDS) * 33'd4;
    localparam logic [PTR_W:0] DEPTH_VAL = (PTR_W + 1)'(TX_FIFO_DEPTH);

    logic [31:0]      ram [RAM_WORDS];
    logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   occupancy;
    logic [IDX_W-1:0] ram_idx;
    logic [1:0]       reg_sel;
    logic             ram_sel;
    logic             mmio_sel;
    logic             wr_ok;
    logic             wr_bad;
    logic             ram_wr;
    logic             leds_wr;
    logic             tx_wr;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             overflow;
    logic [31:0]      cycle_value;
    logic [31:0]      rd_next;

    assign ram_idx  = mem_addr[IDX_W+1:2];
    assign reg_sel  = mem_addr[3:2];
    assign ram_sel  = {1'b0, mem_addr} < RAM_LIMIT;
    assign mmio_sel = mem_addr[31:4] == MMIO_BASE[31:4];
    assign wr_ok    = mem_wr_ena && (mem_addr[1:0] == 2'b00);
    assign wr_bad   = mem_wr_ena && (mem_addr[1:0] != 2'b00);
    assign ram_wr   = wr_ok && ram_sel;
    assign leds_wr  = wr_ok && mmio_sel && (reg_sel == 2'd0);
    assign tx_wr    = wr_ok && mmio_sel && (reg_sel == 2'd1);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign occupancy = wr_ptr - rd_ptr;
    assign full      = occupancy == DEPTH_VAL;
    assign empty     = wr_ptr == rd_ptr;
    assign pop       = !empty && tx_ready;
    assign push      = tx_wr && (!full || pop);
    assign tx_valid  = !empty;
    assign tx_data   = empty ? 8'h00 : fifo_mem[rd_ptr[PTR_W-1:0]];

    // RAM word storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_idx] <= mem_wr_data;
        end
    end

    // FIFO storage; the slot freed by a same-cycle pop is safe to overwrite.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= mem_wr_data[7:0];
        end
    end

    // FIFO pointers and the sticky overflow bit for pushes that were dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (tx_wr && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // LED register.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds <= '0;
        end else if (leds_wr) begin
            leds <= mem_wr_data[15:0];
        end
    end

    // Sticky fault; the address of the first misaligned write is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (wr_bad) begin
            fault <= 1'b1;
            if (!fault) begin
                fault_addr <= mem_addr;
            end
        end
    end

`ifdef RESPONDER_CYCLE_COUNTER_EN
    logic [31:0] cycle_count;

    // Free-running cycle counter; an aligned write to CYCLE zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (wr_ok && mmio_sel && (reg_sel == 2'd3)) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    assign cycle_value = cycle_count;
`else
    assign cycle_value = '0;
`endif

    // Read mux over pre-edge state, so read-during-write returns the old value.
    always_comb begin
        rd_next = '0;
        if (ram_sel) begin
            rd_next = ram[ram_idx];
        end else if (mmio_sel) begin
            case (reg_sel)
                2'd0:    rd_next = {16'h0000, leds};
                2'd1:    rd_next = 32'(occupancy);
                2'd2:    rd_next = {28'h0, overflow, fault, empty, full};
                default: rd_next = cycle_value;
            endcase
        end
    end

    // Registered read data with one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_data <= '0;
        end else begin
            mem_rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_rv32i_memory_responder.sv
// tb_rv32i_memory_responder: directed self-checking bench for rv32i_memory_responder.
// Expected read data is queued when each address is driven and compared when
// the registered read data appears after the following edge.
module tb_rv32i_memory_responder;

    localparam logic [31:0] MMIO = 32'hF000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ena;
    logic [31:0] mem_rd_data;
    logic [15:0] leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        fault;
    logic [31:0] fault_addr;

    typedef struct {
        logic [31:0] value;
        bit          check;
        string       tag;
    } expect_t;

    expect_t scoreboard[$];
    int vectors;
    int miscompares;

    rv32i_memory_responder dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ena  (mem_wr_ena),
        .mem_rd_data (mem_rd_data),
        .leds        (leds),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .fault       (fault),
        .fault_addr  (fault_addr)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, queue the expected read, then compare after the edge.
    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic wena, input logic [31:0] expected,
                                  input bit chk, input string tag);
        expect_t e;
        mem_addr    = addr;
        mem_wr_data = wdata;
        mem_wr_ena  = wena;
        scoreboard.push_back('{expected, chk, tag});
        @(posedge clk);
        #1;
        mem_wr_ena = 1'b0;
        if (scoreboard.size() == 0) begin
            check_output({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = scoreboard.pop_front();
            if (e.check) begin
                check_output(e.tag, mem_rd_data, e.value);
            end
        end
    endtask

    // Directed sequence.
    initial begin
        logic [7:0] drain_bytes [4];
        drain_bytes[0] = 8'h42;
        drain_bytes[1] = 8'h43;
        drain_bytes[2] = 8'h44;
        drain_bytes[3] = 8'h46;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_ena  = 1'b0;
        tx_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_rd_data", mem_rd_data, 32'h0);
        check_output("rst_leds", {16'h0, leds}, 32'h0);
        check_output("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check_output("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check_output("rst_fault", {31'h0, fault}, 32'h0);
        check_output("rst_fault_addr", fault_addr, 32'h0);
        rst = 1'b0;

        // RAM round trip and read-first behaviour.
        apply_stimulus(32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, "ram_wr_10");
        apply_stimulus(32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, "ram_rd_10");
        apply_stimulus(32'h14, 32'h0, 1'b0, 32'h0, 1'b0, "ram_rd_14_dc");
        apply_stimulus(32'h20, 32'h1, 1'b1, 32'h0, 1'b0, "ram_wr_20_a");
        apply_stimulus(32'h20, 32'h2, 1'b1, 32'h1, 1'b1, "ram_read_first");
        apply_stimulus(32'h20, 32'h0, 1'b0, 32'h2, 1'b1, "ram_rd_20_new");

        // LEDS, unmapped space.
        apply_stimulus(MMIO, 32'hABCD_1234, 1'b1, 32'h0, 1'b1, "leds_wr_old");
        check_output("leds_out", {16'h0, leds}, 32'h0000_1234);
        apply_stimulus(MMIO, 32'h0, 1'b0, 32'h0000_1234, 1'b1, "leds_rd");
        apply_stimulus(32'h8000_0000, 32'h0, 1'b0, 32'h0, 1'b1, "unmapped_rd");
        apply_stimulus(32'h4000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, "unmapped_wr");
        check_output("leds_after_unmapped", {16'h0, leds}, 32'h0000_1234);

        // FIFO fill and overflow with the sink stalled.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(MMIO + 32'h4, 32'h41 + 32'(i), 1'b1, (i < 4) ? 32'(i) : 32'd4,
                           1'b1, "fifo_push_occ");
            check_output("fifo_head_stable", {23'h0, tx_valid, tx_data}, 32'h141);
        end
        apply_stimulus(MMIO + 32'h4, 32'h0, 1'b0, 32'd4, 1'b1, "fifo_occ_full");
        apply_stimulus(MMIO + 32'h8, 32'h0, 1'b0, 32'h9, 1'b1, "status_full_ovf");
        apply_stimulus(MMIO + 32'h8, 32'hFFFF_FFFF, 1'b1, 32'h9, 1'b1, "status_wr_ign");
        apply_stimulus(MMIO + 32'h8, 32'h0, 1'b0, 32'h9, 1'b1, "status_after_wr");

        // Push coincident with a pop while full, then drain.
        tx_ready = 1'b1;
        apply_stimulus(MMIO + 32'h4, 32'h46, 1'b1, 32'd4, 1'b1, "push_pop_full");
        apply_stimulus(MMIO + 32'h4, 32'h0, 1'b0, 32'd4, 1'b0, "dummy_idle");
        tx_ready = 1'b0;
        check_output("push_pop_head", {24'h0, tx_data}, 32'h43);
        apply_stimulus(MMIO + 32'h4, 32'h0, 1'b0, 32'd3, 1'b1, "push_pop_occ");
        tx_ready = 1'b1;
        drain_bytes[0] = 8'h43;
        drain_bytes[1] = 8'h44;
        drain_bytes[2] = 8'h46;
        for (int i = 0; i < 3; i++) begin
            check_output("drain_head", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, drain_bytes[i]});
            apply_stimulus(MMIO + 32'h4, 32'h0, 1'b0, 32'(3 - i), 1'b1, "drain_occ");
        end
        check_output("drain_empty", {31'h0, tx_valid}, 32'h0);
        apply_stimulus(MMIO + 32'h8, 32'h0, 1'b0, 32'hA, 1'b1, "status_empty_ovf");
        tx_ready = 1'b0;

        // Misaligned writes.
        apply_stimulus(32'h12, 32'h5555_5555, 1'b1, 32'hDEAD_BEEF, 1'b1, "mis_wr_12");
        check_output("fault_set", {31'h0, fault}, 32'h1);
        apply_stimulus(32'h33, 32'h6666_6666, 1'b1, 32'h0, 1'b0, "mis_wr_33");
        check_output("fault_addr_first", fault_addr, 32'h12);
        apply_stimulus(32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, "mis_suppressed");
        apply_stimulus(MMIO + 32'h8, 32'h0, 1'b0, 32'hE, 1'b1, "status_fault");

        // CYCLE register.
`ifdef RESPONDER_CYCLE_COUNTER_EN
        apply_stimulus(MMIO + 32'hC, 32'h1234, 1'b1, 32'h0, 1'b0, "cycle_clear");
        apply_stimulus(MMIO + 32'hC, 32'h0, 1'b0, 32'd0, 1'b1, "cycle_after_clr");
        apply_stimulus(MMIO + 32'hC, 32'h0, 1'b0, 32'd1, 1'b1, "cycle_inc_1");
        apply_stimulus(MMIO + 32'hC, 32'h0, 1'b0, 32'd2, 1'b1, "cycle_inc_2");
        force dut.cycle_count = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_count;
        apply_stimulus(MMIO + 32'hC, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, "cycle_max");
        apply_stimulus(MMIO + 32'hC, 32'h0, 1'b0, 32'h0, 1'b1, "cycle_wrap");
`else
        apply_stimulus(MMIO + 32'hC, 32'h0, 1'b0, 32'h0, 1'b1, "cycle_absent_rd");
        apply_stimulus(MMIO + 32'hC, 32'h7, 1'b1, 32'h0, 1'b1, "cycle_absent_wr");
        apply_stimulus(MMIO + 32'hC, 32'h0, 1'b0, 32'h0, 1'b1, "cycle_absent_rd2");
`endif

        // Mid-operation reset discards the FIFO and a same-cycle LEDS write.
        apply_stimulus(MMIO + 32'h4, 32'h77, 1'b1, 32'd0, 1'b1, "pre_rst_push");
        check_output("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
        rst = 1'b1;
        apply_stimulus(MMIO, 32'hFFFF, 1'b1, 32'h0, 1'b1, "rst_rd_zero");
        rst = 1'b0;
        check_output("rst2_leds", {16'h0, leds}, 32'h0);
        check_output("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
        check_output("rst2_fault", {31'h0, fault}, 32'h0);
        check_output("rst2_fault_addr", fault_addr, 32'h0);
        apply_stimulus(MMIO + 32'h8, 32'h0, 1'b0, 32'h2, 1'b1, "rst2_status");
        apply_stimulus(32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, "rst2_ram_kept");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
